// File: rtl/sync_tx_arbiter_pkg.sv
// rtl/sync_tx_arbiter_pkg.sv - shared FSM encoding and width helpers for sync_tx_arbiter
package sync_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Width of a requester index; also the tag width carried on the bus
  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Counter must hold the larger of the two reload values (count-1 .. 0)
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_tx_arbiter_rr_arbiter.sv
// rtl/sync_tx_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan upward from ptr, wrapping, and take the first asserted request
  always_comb begin
    int cand;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && |(req & (NUM_REQ'(1) << cand))) begin
        valid  = 1'b1;
        onehot = NUM_REQ'(1) << cand;
        idx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sync_tx_arbiter.sv
// rtl/sync_tx_arbiter.sv - round-robin source-side driver for a shared enable-qualified CDC bus (option: SYNC_TX_ARB_TAG_EN)
module sync_tx_arbiter
  import sync_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
`ifdef SYNC_TX_ARB_TAG_EN
  output logic [WIDTH+tag_width(NUM_REQ)-1:0] sync_data,
`else
  output logic [WIDTH-1:0]           sync_data,
`endif
  output logic                       sync_en
);

  localparam int IDX_W = tag_width(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
`ifdef SYNC_TX_ARB_TAG_EN
  localparam int OUT_W = WIDTH + IDX_W;
`else
  localparam int OUT_W = WIDTH;
`endif

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   rr_ptr, ptr_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [OUT_W-1:0]   data_n;
  logic               en_n;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [WIDTH-1:0]   payload;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr),
    .onehot(win_onehot),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign payload = req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign busy    = (state != IDLE);

  // State, counter and all bus outputs update together; reset drops any transfer in flight
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      sync_data <= '0;
      sync_en   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rr_ptr    <= ptr_n;
      grant     <= grant_n;
      sync_data <= data_n;
      sync_en   <= en_n;
    end
  end

  // Next-state: accept a winner in IDLE, hold enable high, then force a low gap with data frozen
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = rr_ptr;
    grant_n = '0;
    data_n  = sync_data;
    en_n    = sync_en;
    case (state)
      IDLE: begin
        en_n = 1'b0;
        if (win_valid) begin
`ifdef SYNC_TX_ARB_TAG_EN
          data_n = {win_idx, payload};
`else
          data_n = payload;
`endif
          en_n    = 1'b1;
          grant_n = win_onehot;
          ptr_n   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          state_n = HOLD;
        end
      end
      HOLD: begin
        en_n = 1'b1;
        if (cnt == '0) begin
          en_n    = 1'b0;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        en_n = 1'b0;
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        en_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// tb/tb_sync_tx_arbiter.sv - scoreboard bench for sync_tx_arbiter with a 2-stage destination model
module tb_sync_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int HOLD    = 4;
  localparam int GAP     = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);
`ifdef SYNC_TX_ARB_TAG_EN
  localparam int OUT_W = WIDTH + IDX_W;
`else
  localparam int OUT_W = WIDTH;
`endif

  typedef struct {
    int               idx;
    logic [OUT_W-1:0] data;
  } exp_t;

  logic                     CLK = 1'b0;
  logic                     Reset = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [OUT_W-1:0]         sync_data;
  logic                     sync_en;

  exp_t             exp_q[$];
  logic [OUT_W-1:0] exp_cur = '0;
  bit               have_cur = 0;
  int               total = 0;
  int               passed = 0;
  int               grants_seen = 0;
  int               pulses = 0;
  int               cyc = 0;
  int               hi_run = 0;
  int               lo_run = 0;
  bit               seen_first = 0;
  logic             s1, s2, s3;

  sync_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .sync_data(sync_data),
    .sync_en  (sync_en)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t mk(input int idx, input logic [WIDTH-1:0] d);
    exp_t e;
    e.idx = idx;
`ifdef SYNC_TX_ARB_TAG_EN
    e.data = {IDX_W'(idx), d};
`else
    e.data = d;
`endif
    return e;
  endfunction

  task automatic set_data(input int k, input logic [WIDTH-1:0] v);
    req_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grants_seen < target && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    if (grants_seen < target) chk("wait_grant_timeout", 0, grants_seen, target);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    if (busy) chk("wait_idle_timeout", 0, n, budget);
  endtask

  // Monitor: pops the scoreboard on each grant and polices enable run lengths and data stability
  always @(negedge CLK) begin
    cyc++;
    if (!Reset) begin
      hi_run = 0; lo_run = 0; seen_first = 0; have_cur = 0;
    end else begin
      if (grant != '0) begin
        grants_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 0, grant, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant_onehot", grant == NUM_REQ'(1 << e.idx), grant, 1 << e.idx);
          chk("grant_data", sync_data == e.data, sync_data, e.data);
          chk("grant_en", sync_en == 1'b1, sync_en, 1);
          chk("grant_busy", busy == 1'b1, busy, 1);
          exp_cur  = e.data;
          have_cur = 1;
        end
      end else if (busy && have_cur) begin
        chk("data_stable", sync_data == exp_cur, sync_data, exp_cur);
      end
      if (sync_en) begin
        if (seen_first && lo_run > 0) chk("gap_len", lo_run >= GAP + 1, lo_run, GAP + 1);
        lo_run = 0; hi_run++; seen_first = 1;
      end else begin
        if (hi_run > 0) chk("hold_len", hi_run == HOLD, hi_run, HOLD);
        hi_run = 0; lo_run++;
      end
    end
  end

  // Destination model: 2-stage synchronizer plus rising-edge pulse captures the bus
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
    end else begin
      s1 <= sync_en; s2 <= s1; s3 <= s2;
      if (s2 && !s3) begin
        pulses++;
        chk("dest_capture", sync_data == exp_cur, sync_data, exp_cur);
      end
    end
  end

  initial begin
    int g_cyc[5];
    int n;

    repeat (2) @(negedge CLK);
    #1;
    chk("rst_grant", grant == '0, grant, 0);
    chk("rst_busy", busy == 1'b0, busy, 0);
    chk("rst_en", sync_en == 1'b0, sync_en, 0);
    chk("rst_data", sync_data == '0, sync_data, 0);
    Reset = 1'b1;

    // Round robin with all four requesting continuously
    for (int k = 0; k < NUM_REQ; k++) set_data(k, 8'h10 + 8'(k));
    exp_q.push_back(mk(0, 8'h10));
    exp_q.push_back(mk(1, 8'h11));
    exp_q.push_back(mk(2, 8'h12));
    exp_q.push_back(mk(3, 8'h13));
    exp_q.push_back(mk(0, 8'h10));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grants(i + 1, 40);
      g_cyc[i] = cyc;
    end
    req = 4'b0000;
    for (int i = 1; i < 5; i++) chk("rr_period", g_cyc[i] - g_cyc[i-1] == 9, g_cyc[i] - g_cyc[i-1], 9);
    wait_idle(40, n);

    // Single request with payload changed during HOLD
    set_data(2, 8'hA5);
    exp_q.push_back(mk(2, 8'hA5));
    req = 4'b0100;
    wait_grants(6, 40);
    req = 4'b0000;
    set_data(2, 8'h5A);
    wait_idle(40, n);
    chk("single_busy_len", n == 8, n, 8);
    chk("single_idle_data", sync_data == mk(2, 8'hA5).data, sync_data, mk(2, 8'hA5).data);

    // Pointer wrap: after requester 2, pointer is 3 so requester 0 wins first
    set_data(0, 8'h21);
    set_data(1, 8'h22);
    exp_q.push_back(mk(0, 8'h21));
    exp_q.push_back(mk(1, 8'h22));
    req = 4'b0011;
    wait_grants(7, 40);
    req = 4'b0010;
    wait_grants(8, 40);
    req = 4'b0000;
    wait_idle(40, n);

    // Reset during the second HOLD cycle
    set_data(2, 8'h77);
    exp_q.push_back(mk(2, 8'h77));
    req = 4'b0100;
    wait_grants(9, 40);
    req = 4'b0000;
    @(negedge CLK); #2;
    Reset = 1'b0;
    #1;
    chk("mid_rst_en", sync_en == 1'b0, sync_en, 0);
    chk("mid_rst_busy", busy == 1'b0, busy, 0);
    chk("mid_rst_grant", grant == '0, grant, 0);
    chk("mid_rst_data", sync_data == '0, sync_data, 0);
    repeat (2) @(negedge CLK);
    #1;
    set_data(0, 8'h99);
    set_data(3, 8'h3C);
    exp_q.push_back(mk(0, 8'h99));
    exp_q.push_back(mk(3, 8'h3C));
    req = 4'b1001;
    Reset = 1'b1;
    wait_grants(10, 40);
    req = 4'b1000;
    wait_grants(11, 40);
    req = 4'b0000;
    wait_idle(40, n);
    repeat (3) @(negedge CLK);
    #1;

    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    chk("dest_pulse_count", pulses == grants_seen - 1, pulses, grants_seen - 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_tx_arbiter.md
Name: sync_tx_arbiter

Overview:
Source-domain controller that shares one multi-bit CDC crossing (enable-qualified bus synchronizer, NUM_Stages flops plus pulse generator on the destination side) among several requesters. Round-robin arbitration selects one requester at a time. The block then drives a stable registered bus with a level enable held for a programmed number of cycles, followed by a guaranteed low gap so the destination edge detector sees each transfer exactly once.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, payload width per requester
HOLD_CYCLES, 4, cycles sync_en stays high per transfer (>=1; set >= destination NUM_Stages x clock-period ratio + 1)
GAP_CYCLES, 4, cycles sync_en stays low after each transfer (>=1; same sizing rule)

Ports:
CLK  input  1  source-domain clock
Reset  input  1  asynchronous active-low reset
req  input  NUM_REQ  level request per requester, held until granted
req_data  input  NUM_REQ*WIDTH  payloads; requester k occupies bits [k*WIDTH +: WIDTH]
grant  output  NUM_REQ  one-hot, one-cycle pulse: payload accepted
busy  output  1  high whenever state != IDLE
sync_data  output  WIDTH (+TAG_W if ARB_TAG_EN)  registered bus to synchronizer Async_bus
sync_en  output  1  registered level enable to synchronizer bus_EN

Behaviour:
- Reset (async, Reset=0): state=IDLE, grant=0, busy=0, sync_en=0, sync_data=0, rr_ptr=0, counter=0. Applies immediately, including mid-transfer; an in-flight transfer is dropped and its grant is not reissued.
- FSM states: IDLE, HOLD, GAP.
- IDLE: if |req, winner = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ. On the next edge:
  - sync_data <= req_data[winner]; sync_en <= 1; grant[winner] <= 1 for exactly one cycle.
  - rr_ptr <= (winner+1) mod NUM_REQ; counter <= HOLD_CYCLES-1; state <= HOLD.
  - If no req: outputs unchanged, sync_en=0.
- HOLD: sync_en=1, sync_data frozen. Counter decrements each cycle; at 0: sync_en <= 0, counter <= GAP_CYCLES-1, state <= GAP. sync_en is high for exactly HOLD_CYCLES cycles.
- GAP: sync_en=0, sync_data still frozen (must stay stable while the destination may sample). At counter 0, state <= IDLE.
- Minimum transfer period: 1 + HOLD_CYCLES + GAP_CYCLES cycles. Latency from req seen in IDLE to sync_en high: 1 cycle.
- req changes in HOLD/GAP are ignored. A req dropped before its grant is withdrawn, with no error. Simultaneous requests are served strictly round-robin: no requester waits more than NUM_REQ-1 transfers.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). The counter never wraps because reload happens at 0.
- busy rises with sync_en and falls on entry to IDLE.

Optional Feature:
Macro SYNC_TX_ARB_TAG_EN.
- Defined: sync_data widens to WIDTH+TAG_W, TAG_W=$clog2(NUM_REQ). The upper TAG_W bits carry the winner index, latched with the payload, so the destination can demultiplex.
- Undefined: sync_data is WIDTH bits, with no tag logic.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, HOLD=2'b01, GAP=2'b10), TAG_W / counter-width helper functions.
- One sub-module, rr_arbiter: combinational NUM_REQ round-robin priority pick with rr_ptr input, producing one-hot and index outputs. The FSM, counter and output registers stay in sync_tx_arbiter.

Test Plan:
- Single request: HOLD=4, GAP=4; req=4'b0100, data2=8'hA5 -> grant=4'b0100 for 1 cycle; sync_data=8'hA5; sync_en high exactly 4 cycles, then low 4 cycles; busy low after 9 cycles.
- Round-robin fairness: req=4'b1111 held continuously, data k = 8'h10+k -> grants in order 0,1,2,3,0; sync_data sequence 10,11,12,13,10; period 9 cycles.
- Pointer wrap: after serving requester 3, assert req=4'b0011 -> requester 0 is granted first, then 1.
- Data stability: change req_data of the granted requester during HOLD/GAP -> sync_data unchanged until the next grant. The end-to-end bench with the destination synchronizer (NUM_Stages=2) shows exactly one EN_pulse per transfer with the correct value.
- Reset mid-HOLD: deassert Reset at cycle 2 of HOLD -> sync_en, busy, grant and sync_data go to 0 immediately. After release with req=4'b0001, requester 0 is granted (rr_ptr=0).
- SYNC_TX_ARB_TAG_EN defined: req=4'b1000, data=8'h3C -> sync_data=10'b11_0011_1100.
